muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq_pkg.sv | 25 ++
 rtl/mdu_timer.sv | 31 +++
 rtl/muldiv_seq.sv | 143 ++++++++++++++
 tb/tb_muldiv_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: MDU op codes,
// controller state encoding and default latencies.
package muldiv_seq_pkg;

  localparam logic [4:0] MDU_none  = 5'd0;
  localparam logic [4:0] MDU_mult  = 5'd1;
  localparam logic [4:0] MDU_multu = 5'd2;
  localparam logic [4:0] MDU_div   = 5'd3;
  localparam logic [4:0] MDU_divu  = 5'd4;
  localparam logic [4:0] MDU_mfhi  = 5'd5;
  localparam logic [4:0] MDU_mflo  = 5'd6;
  localparam logic [4:0] MDU_mthi  = 5'd7;
  localparam logic [4:0] MDU_mtlo  = 5'd8;

  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_timer.sv
// Loadable down-counter that times an in-flight MDU operation; done marks
// the last busy cycle (count == 1).
module mdu_timer
  import muldiv_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == CNT_W'(1));

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. Results are
// computed at issue, held pending, and committed when the timer expires.
// Optional MDU_CANCEL_EN adds a cancel input that aborts an in-flight op.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_is_md,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);

  mdu_state_e       state_reg, state_next;
  logic             timer_load, timer_done, commit, cancel_in, start_ok, abort;
  logic [CNT_W-1:0] timer_val;
  logic [31:0]      hi_reg, lo_reg, pend_hi_reg, pend_lo_reg;
  logic             pend_dz_reg;
  logic [63:0]      a_sx, b_sx, prod_s, prod_u;
  logic [31:0]      divisor, quot_u, rem_u;
  logic signed [31:0] a_s, d_s, quot_s, rem_s;

`ifdef MDU_CANCEL_EN
  assign cancel_in = cancel;
`else
  assign cancel_in = 1'b0;
`endif

  assign busy     = (state_reg != IDLE);
  assign stall    = d_is_md & (start | busy);
  assign start_ok = start & ~cancel_in;
  assign abort    = busy & cancel_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_val  = '0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_ok && (MDU_op == MDU_mult || MDU_op == MDU_multu)) begin
          state_next = MUL;
          timer_load = 1'b1;
          timer_val  = CNT_W'(MUL_CYCLES);
        end else if (start_ok && (MDU_op == MDU_div || MDU_op == MDU_divu)) begin
          state_next = DIV;
          timer_load = 1'b1;
          timer_val  = CNT_W'(DIV_CYCLES);
        end
      end
      MUL, DIV: begin
        if (abort) begin
          state_next = IDLE;
        end else if (timer_done) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  mdu_timer u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (busy),
    .clr      (abort),
    .done     (timer_done)
  );

  // Low 64 bits of the sign-extended product equal the signed product.
  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divide-by-zero result is discarded at commit, so a safe divisor avoids X.
  assign divisor = (B == 32'd0) ? 32'd1 : B;
  assign a_s     = A;
  assign d_s     = divisor;
  assign quot_s  = a_s / d_s;
  assign rem_s   = a_s % d_s;
  assign quot_u  = A / divisor;
  assign rem_u   = A % divisor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      pend_dz_reg <= 1'b0;
    end else if (timer_load) begin
      pend_dz_reg <= (B == 32'd0) && (MDU_op == MDU_div || MDU_op == MDU_divu);
      case (MDU_op)
        MDU_mult:  {pend_hi_reg, pend_lo_reg} <= prod_s;
        MDU_multu: {pend_hi_reg, pend_lo_reg} <= prod_u;
        MDU_div:   {pend_hi_reg, pend_lo_reg} <= {rem_s, quot_s};
        MDU_divu:  {pend_hi_reg, pend_lo_reg} <= {rem_u, quot_u};
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (commit) begin
      if (!pend_dz_reg) begin
        hi_reg <= pend_hi_reg;
        lo_reg <= pend_lo_reg;
      end
    end else if (state_reg == IDLE && !start) begin
      if (MDU_op == MDU_mthi) hi_reg <= A;
      if (MDU_op == MDU_mtlo) lo_reg <= A;
    end
  end

  assign HI      = hi_reg;
  assign LO      = lo_reg;
  assign rd_data = (MDU_op == MDU_mfhi) ? hi_reg :
                   (MDU_op == MDU_mflo) ? lo_reg : 32'd0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO and latency are queued at
// issue and compared when the unit drops busy.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, d_is_md;
  logic [4:0]  MDU_op;
  logic [31:0] A, B;
  logic        busy, stall;
  logic [31:0] HI, LO, rd_data;
`ifdef MDU_CANCEL_EN
  logic        cancel = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    bit          dz;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  int          vectors = 0, miscompares = 0;

  muldiv_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .MDU_op  (MDU_op),
    .A       (A),
    .B       (B),
    .d_is_md (d_is_md),
`ifdef MDU_CANCEL_EN
    .cancel  (cancel),
`endif
    .busy    (busy),
    .stall   (stall),
    .HI      (HI),
    .LO      (LO),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  // Reference model: sign handled via magnitudes, independent of $signed.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input string nm);
    exp_t        e;
    logic [63:0] p;
    logic [31:0] q, r;
    e.name = nm;
    e.dz   = 1'b0;
    if (op == MDU_mult || op == MDU_multu) begin
      e.cyc = 5;
      if (op == MDU_mult) begin
        p = {32'd0, mag(a)} * {32'd0, mag(b)};
        if (a[31] ^ b[31]) p = ~p + 64'd1;
      end else begin
        p = {32'd0, a} * {32'd0, b};
      end
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
      e.cyc = 10;
      if (b == 32'd0) begin
        e.dz = 1'b1;
        e.hi = 32'd0;
        e.lo = 32'd0;
      end else if (op == MDU_div) begin
        q = mag(a) / mag(b);
        r = mag(a) % mag(b);
        e.lo = (a[31] ^ b[31]) ? (~q + 32'd1) : q;
        e.hi = a[31] ? (~r + 32'd1) : r;
      end else begin
        e.lo = a / b;
        e.hi = a % b;
      end
    end
    return e;
  endfunction

  // Issue at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string nm);
    sb.push_back(model(op, a, b, nm));
    start = 1'b1; MDU_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; MDU_op = MDU_none;
  endtask

  // Scoreboard consumer: waits out busy, pops the entry and compares it.
  task automatic sb_collect();
    exp_t e;
    int   n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty: got completion, required a queued expectation");
      return;
    end
    e = sb.pop_front();
    if (e.dz) begin e.hi = m_hi; e.lo = m_lo; end
    if (n !== e.cyc) begin
      miscompares++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", e.name, n, e.cyc);
    end
    vectors++;
    if (HI !== e.hi) begin
      miscompares++;
      $display("FAIL %s_hi: got %08h, required %08h", e.name, HI, e.hi);
    end
    vectors++;
    if (LO !== e.lo) begin
      miscompares++;
      $display("FAIL %s_lo: got %08h, required %08h", e.name, LO, e.lo);
    end
    MDU_op = MDU_mflo; #1;
    vectors++;
    if (rd_data !== e.lo) begin
      miscompares++;
      $display("FAIL %s_mflo: got %08h, required %08h", e.name, rd_data, e.lo);
    end
    MDU_op = MDU_none;
    m_hi = e.hi; m_lo = e.lo;
    $display("done %-8s cycles=%0d HI=%08h LO=%08h", e.name, n, HI, LO);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; d_is_md = 1'b1; MDU_op = MDU_mult;
    A = 32'd3; B = 32'd4;
    #2;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    vectors++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      miscompares++; $display("FAIL reset_hilo: got %08h/%08h, required 0/0", HI, LO);
    end
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall: got %b, required 1", stall); end
    start = 1'b0; d_is_md = 1'b0; MDU_op = MDU_none; #1;
    vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall_idle: got %b, required 0", stall); end
    @(posedge clk); #1;
    reset = 1'b1;
    $display("reset released");
  endtask

  // mult issued on the first edge after reset; stall tracked, mthi mid-busy ignored.
  task automatic test_mult_stall();
    int n = 0, stall_cnt = 0;
    exp_t e;
    sb.push_back(model(MDU_mult, 32'hFFFF_FFFF, 32'd2, "mult"));
    d_is_md = 1'b1; start = 1'b1; MDU_op = MDU_mult; A = 32'hFFFF_FFFF; B = 32'd2;
    #1;
    if (stall === 1'b1) stall_cnt++;
    @(posedge clk); #1;
    start = 1'b0; MDU_op = MDU_none;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (stall === 1'b1) stall_cnt++;
      if (n == 2) begin MDU_op = MDU_mthi; A = 32'h1234; end
      else if (n == 3) MDU_op = MDU_none;
      @(posedge clk); #1;
    end
    d_is_md = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (n !== e.cyc) begin miscompares++; $display("FAIL mult_busy_cycles: got %0d, required %0d", n, e.cyc); end
    vectors++;
    if (stall_cnt !== 6) begin miscompares++; $display("FAIL mult_stall_cycles: got %0d, required 6", stall_cnt); end
    vectors++;
    if (HI !== e.hi) begin miscompares++; $display("FAIL mult_hi: got %08h, required %08h", HI, e.hi); end
    vectors++;
    if (LO !== e.lo) begin miscompares++; $display("FAIL mult_lo: got %08h, required %08h", LO, e.lo); end
    m_hi = e.hi; m_lo = e.lo;
    $display("done mult     cycles=%0d stall=%0d HI=%08h LO=%08h", n, stall_cnt, HI, LO);
  endtask

  task automatic test_multu();
    issue(MDU_multu, 32'hFFFF_FFFF, 32'd2, "multu");
    sb_collect();
  endtask

  task automatic test_div();
    issue(MDU_div, 32'hFFFF_FFF9, 32'd2, "div");
    sb_collect();
    issue(MDU_divu, 32'd7, 32'd0, "divu_z");
    sb_collect();
  endtask

  task automatic test_mt();
    MDU_op = MDU_mthi; A = 32'h1234_5678; @(posedge clk); #1;
    MDU_op = MDU_mtlo; A = 32'h9ABC_DEF0; @(posedge clk); #1;
    MDU_op = MDU_mfhi; #1;
    vectors++;
    if (rd_data !== 32'h1234_5678) begin miscompares++; $display("FAIL mfhi: got %08h, required 12345678", rd_data); end
    MDU_op = MDU_mflo; #1;
    vectors++;
    if (rd_data !== 32'h9ABC_DEF0) begin miscompares++; $display("FAIL mflo: got %08h, required 9abcdef0", rd_data); end
    MDU_op = MDU_none; #1;
    vectors++;
    if (rd_data !== 32'd0) begin miscompares++; $display("FAIL rd_none: got %08h, required 0", rd_data); end
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
    $display("done mthi/mtlo HI=%08h LO=%08h", HI, LO);
  endtask

  task automatic test_back_to_back();
    logic [4:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0: op = MDU_mult;
        1: op = MDU_multu;
        2: op = MDU_div;
        default: op = MDU_divu;
      endcase
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 4 == 1) b = -b;
      if (b == 32'd0) b = 32'd3;
      if (op == MDU_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      issue(op, a, b, "b2b");
      sb_collect();
    end
  endtask

  task automatic test_reset_abort();
    issue(MDU_div, 32'd100, 32'd7, "div_abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    sb.delete();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b, required 0", busy); end
    vectors++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      miscompares++; $display("FAIL abort_hilo: got %08h/%08h, required 0/0", HI, LO);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (15) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_no_commit: got busy=%b HI=%08h LO=%08h, required 0/0/0", busy, HI, LO);
    end
    $display("done reset abort HI=%08h LO=%08h", HI, LO);
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel();
    MDU_op = MDU_mthi; A = 32'hAAAA; @(posedge clk); #1;
    MDU_op = MDU_mtlo; A = 32'hAAAA; @(posedge clk); #1;
    issue(MDU_mult, 32'd3, 32'd5, "mult_cancel");
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    sb.delete();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL cancel_busy: got %b, required 0", busy); end
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (HI !== 32'hAAAA || LO !== 32'hAAAA) begin
      miscompares++; $display("FAIL cancel_hilo: got %08h/%08h, required 0000aaaa/0000aaaa", HI, LO);
    end
    m_hi = 32'hAAAA; m_lo = 32'hAAAA;
    $display("done cancel HI=%08h LO=%08h", HI, LO);
  endtask
`endif

  initial begin
    test_reset();
    test_mult_stall();
    test_multu();
    test_div();
    test_mt();
    test_back_to_back();
    test_reset_abort();
`ifdef MDU_CANCEL_EN
    test_cancel();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
